// File: rtl/exec_stage_if.sv
// Execute-stage bus: ID/EX inputs, redirect outputs and EX/MEM register.
// master = decode/testbench side, slave = exec_stage.
interface exec_stage_if #(
    parameter int XLEN = 32,
    parameter int OPW  = 6
);
    logic [OPW-1:0]  alu_op;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] next_pc_in;
    logic            rd_write_enable;
    logic [4:0]      rd_write_addr;
    logic            res_src;
    logic            branch;
    logic            jump;
    logic            mem_write_enable;
    logic            alu_input_conf;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    logic [XLEN-1:0] target_pc;
    logic            pc_src;
    logic            rd_write_enable_out;
    logic [4:0]      rd_write_addr_out;
    logic            res_src_out;
    logic            mem_write_enable_out;
    logic [XLEN-1:0] exec_out;
    logic [XLEN-1:0] mem_write_data_out;
    logic [XLEN-1:0] next_pc_out;

    modport master (
        output alu_op, pc_in, next_pc_in, rd_write_enable, rd_write_addr,
               res_src, branch, jump, mem_write_enable, alu_input_conf,
               imm, rs1_data, rs2_data,
        input  target_pc, pc_src, rd_write_enable_out, rd_write_addr_out,
               res_src_out, mem_write_enable_out, exec_out,
               mem_write_data_out, next_pc_out
    );

    modport slave (
        input  alu_op, pc_in, next_pc_in, rd_write_enable, rd_write_addr,
               res_src, branch, jump, mem_write_enable, alu_input_conf,
               imm, rs1_data, rs2_data,
        output target_pc, pc_src, rd_write_enable_out, rd_write_addr_out,
               res_src_out, mem_write_enable_out, exec_out,
               mem_write_data_out, next_pc_out
    );
endinterface

// File: rtl/exec_stage.sv
// RV32I execute stage: ALU, branch/jump resolution, EX/MEM register.
// Ports: clk, rst (sync, active-high), bus (exec_stage_if.slave).
module exec_stage #(
    parameter int XLEN = 32,
    parameter int OPW  = 6
) (
    input  logic         clk,
    input  logic         rst,
    exec_stage_if.slave  bus
);
    localparam logic [OPW-1:0] OP_ADD   = 6'd0;
    localparam logic [OPW-1:0] OP_SUB   = 6'd1;
    localparam logic [OPW-1:0] OP_AND   = 6'd2;
    localparam logic [OPW-1:0] OP_OR    = 6'd3;
    localparam logic [OPW-1:0] OP_XOR   = 6'd4;
    localparam logic [OPW-1:0] OP_SLL   = 6'd5;
    localparam logic [OPW-1:0] OP_SRL   = 6'd6;
    localparam logic [OPW-1:0] OP_SRA   = 6'd7;
    localparam logic [OPW-1:0] OP_SLT   = 6'd8;
    localparam logic [OPW-1:0] OP_SLTU  = 6'd9;
    localparam logic [OPW-1:0] OP_PASSB = 6'd10;
    localparam logic [OPW-1:0] OP_AUIPC = 6'd11;
    localparam logic [OPW-1:0] OP_JALR  = 6'd12;
    localparam logic [OPW-1:0] OP_BEQ   = 6'd16;
    localparam logic [OPW-1:0] OP_BNE   = 6'd17;
    localparam logic [OPW-1:0] OP_BLT   = 6'd18;
    localparam logic [OPW-1:0] OP_BGE   = 6'd19;
    localparam logic [OPW-1:0] OP_BLTU  = 6'd20;
    localparam logic [OPW-1:0] OP_BGEU  = 6'd21;

    localparam logic [XLEN-1:0] ZERO = '0;

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      shamt;
    logic            lt_s;
    logic            lt_u;
    logic            eq;
    logic [XLEN-1:0] alu_res;
    logic            cond;
    logic [XLEN-1:0] jalr_sum;
    logic            is_jalr;

    assign op_a  = bus.rs1_data;
    assign op_b  = bus.alu_input_conf ? bus.rs2_data : bus.imm;
    assign shamt = op_b[4:0];
    assign lt_s  = $signed(op_a) < $signed(op_b);
    assign lt_u  = op_a < op_b;
    assign eq    = op_a == op_b;

    always_comb begin
        alu_res = ZERO;
        cond    = 1'b0;
        case (bus.alu_op)
            OP_ADD:   alu_res = op_a + op_b;
            OP_SUB:   alu_res = op_a - op_b;
            OP_AND:   alu_res = op_a & op_b;
            OP_OR:    alu_res = op_a | op_b;
            OP_XOR:   alu_res = op_a ^ op_b;
            OP_SLL:   alu_res = op_a << shamt;
            OP_SRL:   alu_res = op_a >> shamt;
            OP_SRA:   alu_res = $unsigned($signed(op_a) >>> shamt);
            OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, lt_s};
            OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, lt_u};
            OP_PASSB: alu_res = op_b;
            OP_AUIPC: alu_res = bus.pc_in + op_b;
            OP_JALR:  alu_res = op_a + op_b;
            OP_BEQ:   cond = eq;
            OP_BNE:   cond = !eq;
            OP_BLT:   cond = lt_s;
            OP_BGE:   cond = !lt_s;
            OP_BLTU:  cond = lt_u;
            OP_BGEU:  cond = !lt_u;
            default: begin
                alu_res = ZERO;
                cond    = 1'b0;
            end
        endcase
    end

    // Redirect uses imm directly, independent of the operand-B mux.
    assign is_jalr  = bus.jump && (bus.alu_op == OP_JALR);
    assign jalr_sum = bus.rs1_data + bus.imm;

    assign bus.target_pc = is_jalr
        ? (jalr_sum & {{(XLEN-1){1'b1}}, 1'b0})
        : (bus.pc_in + bus.imm);
    assign bus.pc_src = bus.jump | (bus.branch & cond);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_write_enable_out  <= 1'b0;
            bus.rd_write_addr_out    <= 5'd0;
            bus.res_src_out          <= 1'b0;
            bus.mem_write_enable_out <= 1'b0;
            bus.exec_out             <= ZERO;
            bus.mem_write_data_out   <= ZERO;
            bus.next_pc_out          <= ZERO;
        end else begin
            bus.rd_write_enable_out  <= bus.rd_write_enable;
            bus.rd_write_addr_out    <= bus.rd_write_addr;
            bus.res_src_out          <= bus.res_src;
            bus.mem_write_enable_out <= bus.mem_write_enable;
            // Jumps write the link address back through the result path.
            bus.exec_out             <= bus.jump ? bus.next_pc_in : alu_res;
            bus.mem_write_data_out   <= bus.rs2_data;
            bus.next_pc_out          <= bus.next_pc_in;
        end
    end
endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard testbench for exec_stage.
// Directed test-plan vectors followed by randomized traffic.
module tb_exec_stage;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    exec_stage_if bus ();

    exec_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        rwe;
        logic [4:0]  rwa;
        logic        rs;
        logic        mwe;
        logic [31:0] exec;
        logic [31:0] mwd;
        logic [31:0] npc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    function automatic logic [31:0] pow2(input logic [4:0] s);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 0; i < int'(s); i++) p = p * 32'd2;
        return p;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [5:0] op,
            input logic [31:0] a, input logic [31:0] b,
            input logic [31:0] pc);
        logic [31:0] p;
        logic [31:0] r;
        p = pow2(b[4:0]);
        r = 32'd0;
        case (int'(op))
            0:  r = a + b;
            1:  r = a + (~b + 32'd1);
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = a * p;
            6:  r = a / p;
            7:  r = (a / p) | (a[31] ? ~(32'hFFFF_FFFF / p) : 32'd0);
            8:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            9:  r = (longint'({32'd0, a}) < longint'({32'd0, b})) ? 32'd1 : 32'd0;
            10: r = b;
            11: r = pc + b;
            12: r = a + b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic cond_ref(input logic [5:0] op,
            input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        longint ua, ub;
        sa = int'(a);
        sb = int'(b);
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (int'(op))
            16: return a == b;
            17: return a != b;
            18: return sa < sb;
            19: return sa >= sb;
            20: return ua < ub;
            21: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
            input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic [5:0] op,
            input logic [31:0] pc, input logic [31:0] rs1,
            input logic [31:0] rs2, input logic [31:0] imm,
            input logic conf, input logic br, input logic jp,
            input logic rwe, input logic [4:0] rwa,
            input logic rs, input logic mwe);
        logic [31:0] b, res, tgt, jsum;
        logic        c, psrc;
        exp_t        e;
        @(negedge clk);
        rst                  = r;
        bus.alu_op           = op;
        bus.pc_in            = pc;
        bus.next_pc_in       = pc + 32'd4;
        bus.rs1_data         = rs1;
        bus.rs2_data         = rs2;
        bus.imm              = imm;
        bus.alu_input_conf   = conf;
        bus.branch           = br;
        bus.jump             = jp;
        bus.rd_write_enable  = rwe;
        bus.rd_write_addr    = rwa;
        bus.res_src          = rs;
        bus.mem_write_enable = mwe;
        b    = conf ? rs2 : imm;
        res  = alu_ref(op, rs1, b, pc);
        c    = cond_ref(op, rs1, b);
        jsum = rs1 + imm;
        tgt  = (jp && op == 6'd12) ? {jsum[31:1], 1'b0} : pc + imm;
        psrc = jp || (br && c);
        #1;
        chk("target_pc", bus.target_pc, tgt);
        chk("pc_src", {31'd0, bus.pc_src}, {31'd0, psrc});
        if (r) e = '0;
        else e = '{rwe: rwe, rwa: rwa, rs: rs, mwe: mwe,
                   exec: jp ? pc + 32'd4 : res, mwd: rs2,
                   npc: pc + 32'd4};
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rd_write_enable_out", {31'd0, bus.rd_write_enable_out}, {31'd0, e.rwe});
                chk("rd_write_addr_out", {27'd0, bus.rd_write_addr_out}, {27'd0, e.rwa});
                chk("res_src_out", {31'd0, bus.res_src_out}, {31'd0, e.rs});
                chk("mem_write_enable_out", {31'd0, bus.mem_write_enable_out}, {31'd0, e.mwe});
                chk("exec_out", bus.exec_out, e.exec);
                chk("mem_write_data_out", bus.mem_write_data_out, e.mwd);
                chk("next_pc_out", bus.next_pc_out, e.npc);
            end
        end
    end

    logic [5:0] ops [13] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6,
                             6'd7, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12};

    initial begin : driver
        logic [5:0]  op;
        logic [31:0] a, pc;
        logic        br;
        rst = 1'b1;
        bus.alu_op = '0; bus.pc_in = '0; bus.next_pc_in = '0;
        bus.rs1_data = '0; bus.rs2_data = '0; bus.imm = '0;
        bus.alu_input_conf = 1'b0; bus.branch = 1'b0; bus.jump = 1'b0;
        bus.rd_write_enable = 1'b0; bus.rd_write_addr = '0;
        bus.res_src = 1'b0; bus.mem_write_enable = 1'b0;

        // reset with non-zero inputs pending
        apply(1, 6'd0, 32'h40, 32'h11, 32'h22, 32'h4, 1, 0, 0, 1, 5'd3, 1, 1);
        apply(0, 6'd0, 32'h0, 32'h1, 32'h2, 32'h0, 1, 0, 0, 0, 5'd0, 0, 0);
        apply(0, 6'd1, 32'h0, 32'h1, 32'h2, 32'h0, 1, 0, 0, 0, 5'd0, 0, 0);
        apply(0, 6'd8, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0, 0, 0, 5'd0, 0, 0);
        apply(0, 6'd9, 32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0, 0, 0, 5'd0, 0, 0);
        apply(0, 6'd7, 32'h0, 32'h8000_0000, 32'h4, 32'h0, 1, 0, 0, 0, 5'd0, 0, 0);
        apply(0, 6'd0, 32'h0, 32'h10, 32'h55, 32'hFFFF_FFFC, 0, 0, 0, 0, 5'd0, 0, 0);
        apply(0, 6'd16, 32'h100, 32'h5, 32'h5, 32'h20, 1, 1, 0, 0, 5'd0, 0, 0);
        apply(0, 6'd16, 32'h100, 32'h5, 32'h6, 32'h20, 1, 1, 0, 0, 5'd0, 0, 0);
        apply(0, 6'd12, 32'h100, 32'h203, 32'h0, 32'h4, 0, 0, 1, 1, 5'd1, 0, 0);
        apply(0, 6'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1, 0, 0, 1, 5'd7, 1, 1);
        apply(0, 6'd5, 32'h0, 32'h1, 32'h3F, 32'h0, 1, 0, 0, 0, 5'd0, 0, 0);
        apply(0, 6'd16, 32'h200, 32'h1, 32'h2, 32'h8, 1, 1, 1, 0, 5'd0, 0, 0);
        apply(0, 6'd63, 32'h0, 32'h7, 32'h7, 32'h0, 1, 1, 0, 0, 5'd0, 0, 0);
        // reset mid-stream
        apply(1, 6'd0, 32'h300, 32'h9, 32'h9, 32'h0, 1, 1, 0, 1, 5'd9, 1, 1);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
            else if ($urandom_range(0, 2) == 0) op = 6'($urandom_range(16, 21));
            else op = ops[$urandom_range(0, 12)];
            br = (op >= 6'd16 && op <= 6'd21) ? 1'($urandom_range(0, 1))
                                              : ($urandom_range(0, 15) == 0);
            a  = $urandom;
            pc = $urandom & 32'hFFFF_FFFC;
            apply($urandom_range(0, 31) == 0, op, pc, a,
                  ($urandom_range(0, 3) == 0) ? a : 32'($urandom),
                  ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom),
                  1'($urandom_range(0, 1)), br, $urandom_range(0, 7) == 0,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("queue_drain", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute stage of the 5-stage RV32I pipeline; sits between decode (ID/EX) and memory (EX/MEM).
- Selects ALU operands and computes the ALU result.
- Resolves branches and jumps combinationally; drives target_pc/pc_src back to fetch.
- Registers the control and data bundle into the EX/MEM pipeline register on each rising clock edge.

Parameters:
- XLEN, 32, datapath width.
- OPW, 6, alu_op width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- alu_op  in  6  operation code.
- pc_in  in  32  PC of the instruction in EX.
- next_pc_in  in  32  pc_in+4.
- rd_write_enable  in  1  register-file write request.
- rd_write_addr  in  5  destination register.
- res_src  in  1  writeback source, 0=ALU, 1=memory.
- branch  in  1  conditional-branch instruction.
- jump  in  1  JAL/JALR instruction.
- mem_write_enable  in  1  store instruction.
- alu_input_conf  in  1  operand B select, 1=rs2_data, 0=imm.
- imm  in  32  sign-extended immediate.
- rs1_data  in  32  operand A.
- rs2_data  in  32  rs2 value, also store data.
- target_pc  out  32  redirect address (combinational).
- pc_src  out  1  take redirect (combinational).
- rd_write_enable_out, rd_write_addr_out(5), res_src_out, mem_write_enable_out  out  registered copies of the inputs.
- exec_out  out  32  registered result.
- mem_write_data_out  out  32  registered rs2_data.
- next_pc_out  out  32  registered next_pc_in.

Behaviour:
- Operands: A=rs1_data; B = alu_input_conf ? rs2_data : imm.
- alu_op encodings (constants.v macros), result R:
  - ADD=0: A+B.
  - SUB=1: A-B.
  - AND=2, OR=3, XOR=4: bitwise.
  - SLL=5: A<<B[4:0].
  - SRL=6: logical right shift by B[4:0].
  - SRA=7: arithmetic right shift by B[4:0].
  - SLT=8: signed A<B ? 1 : 0.
  - SLTU=9: unsigned A<B ? 1 : 0.
  - PASSB=10: B (LUI).
  - AUIPC=11: pc_in+B.
  - JALR=12: A+B (address computation).
  - BEQ=16, BNE=17, BLT=18, BGE=19, BLTU=20, BGEU=21: condition cond computed on A vs B; R=0.
  - Any undefined code: R=0, cond=0.
- All arithmetic is modulo 2^32; overflow is ignored; shifts use only B[4:0].
- Redirect (combinational, same cycle):
  - target_pc = (jump && alu_op==JALR) ? ((rs1_data+imm) & ~1) : pc_in+imm.
  - pc_src = jump | (branch & cond).
  - pc_src is never asserted while branch=jump=0.
- Result: exec_out D-input = jump ? next_pc_in : R. JAL/JALR write the link address through the ALU path.
- Registered outputs:
  - Update on every rising clk edge; latency is 1 cycle; there is no stall or flush input.
  - When rst=1 at an edge, all registered outputs go to 0, including the enables, so reset mid-stream drops the in-flight instruction.
  - target_pc and pc_src are unaffected by rst (purely combinational).
- Simultaneous branch and jump: jump takes priority for target_pc; pc_src=1.

Test Plan:
- rst=1 for one edge, then release -> all registered outputs 0; first post-reset edge with ADD, rs1=1, rs2=2, conf=1 -> exec_out=0x00000003 after that edge.
- SUB 1-2 -> 0xFFFFFFFF; SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0; SRA 0x80000000 by 4 -> 0xF8000000.
- conf=0, ADD, rs1=0x10, imm=0xFFFFFFFC, rs2=0x55 -> exec_out=0xC, mem_write_data_out=0x55.
- BEQ branch=1, pc_in=0x100, imm=0x20, rs1=rs2=5 -> pc_src=1, target_pc=0x120 same cycle; rs2=6 -> pc_src=0.
- JALR jump=1, rs1=0x203, imm=4, next_pc_in=0x104 -> target_pc=0x206, pc_src=1, exec_out=0x104 after edge.
- Pass-through: rd_write_enable=1, rd_write_addr=7, res_src=1, mem_write_enable=1 -> identical values on *_out one edge later.
